// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the writeback stage.
// Holds opcode and load funct3 encodings, the WB queue-entry struct
// and a helper that recognises the supported load widths.
package rv32i_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ir;
      logic        wen;
      logic [4:0]  rd;
      logic [31:0] wdata;
   } wb_entry_t;

   // True for the load widths the core implements.
   function automatic logic load_f3_ok(input logic [2:0] f3);
      logic ok;
      case (f3)
         F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
         default:                             ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/wb_load_align.sv
// Load data alignment and extension.
// Ports:
//   funct3_i   load width / signedness
//   offset_i   byte offset within the word (effective address [1:0])
//   raw_i      raw aligned word from data memory
//   data_o     extended load result (0 for unsupported funct3)
//   misalign_o access not naturally aligned for its width
module wb_load_align
   import rv32i_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] raw_i,
   output logic [31:0] data_o,
   output logic        misalign_o
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Pick the addressed byte and halfword out of the raw word.
   always_comb begin
      case (offset_i)
         2'd0:    byte_s = raw_i[7:0];
         2'd1:    byte_s = raw_i[15:8];
         2'd2:    byte_s = raw_i[23:16];
         2'd3:    byte_s = raw_i[31:24];
         default: byte_s = 8'd0;
      endcase
      half_s = offset_i[1] ? raw_i[31:16] : raw_i[15:0];
   end

   // Extend per funct3 and flag width-misaligned accesses.
   always_comb begin
      data_o     = 32'd0;
      misalign_o = 1'b0;
      case (funct3_i)
         F3_LB:  data_o = {{24{byte_s[7]}}, byte_s};
         F3_LBU: data_o = {24'd0, byte_s};
         F3_LH: begin
            data_o     = {{16{half_s[15]}}, half_s};
            misalign_o = offset_i[0];
         end
         F3_LHU: begin
            data_o     = {16'd0, half_s};
            misalign_o = offset_i[0];
         end
         F3_LW: begin
            data_o     = raw_i;
            misalign_o = (offset_i != 2'd0);
         end
         default: begin
            data_o     = 32'd0;
            misalign_o = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// RV32I writeback stage: forms the architectural result of each completed
// instruction, buffers it in an in-order queue and drains it into the
// register-file write port, counting retired instructions.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   mem_valid/mem_ready         handshake from the memory stage
//   mem_pc/ir/alu_out/load_data instruction payload
//   flush                       synchronous queue clear
//   rf_ready                    register-file port available
//   rf_we/rf_waddr/rf_wdata     register-file write port
//   retire_valid/pc/ir          retirement report
//   misalign_err                pulse after a misaligned load is accepted
//   instret                     retired-instruction counter
module writeback_stage
   import rv32i_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int XLEN  = 32,
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_valid,
   output logic             mem_ready,
   input  logic [XLEN-1:0]  mem_pc,
   input  logic [XLEN-1:0]  mem_ir,
   input  logic [XLEN-1:0]  mem_alu_out,
   input  logic [XLEN-1:0]  mem_load_data,
   input  logic             flush,
   input  logic             rf_ready,
   output logic             rf_we,
   output logic [4:0]       rf_waddr,
   output logic [XLEN-1:0]  rf_wdata,
   output logic             retire_valid,
   output logic [XLEN-1:0]  retire_pc,
   output logic [XLEN-1:0]  retire_ir,
   output logic             misalign_err,
   output logic [CNT_W-1:0] instret
);

   localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   wb_entry_t        queue_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic             misalign_q, misalign_d;

   wb_entry_t   new_entry_s, head_s;
   logic        push_s, pop_s, wen_raw_s, load_mis_s, entry_mis_s;
   logic [6:0]  opcode_s;
   logic [2:0]  funct3_s;
   logic [4:0]  rd_s;
   logic [31:0] load_data_s;

   assign opcode_s = mem_ir[6:0];
   assign funct3_s = mem_ir[14:12];
   assign rd_s     = mem_ir[11:7];

   wb_load_align u_align (
      .funct3_i   (funct3_s),
      .offset_i   (mem_alu_out[1:0]),
      .raw_i      (mem_load_data),
      .data_o     (load_data_s),
      .misalign_o (load_mis_s)
   );

   // Build the queue entry from the incoming instruction.
   always_comb begin
      wen_raw_s         = 1'b0;
      entry_mis_s       = 1'b0;
      new_entry_s.pc    = mem_pc;
      new_entry_s.ir    = mem_ir;
      new_entry_s.rd    = rd_s;
      new_entry_s.wdata = 32'd0;
      case (opcode_s)
         OPC_LOAD: begin
            new_entry_s.wdata = load_data_s;
            wen_raw_s         = load_f3_ok(funct3_s) && !load_mis_s;
            entry_mis_s       = load_mis_s;
         end
         OPC_JAL, OPC_JALR: begin
            new_entry_s.wdata = mem_pc + 32'd4;
            wen_raw_s         = 1'b1;
         end
         OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OP_IMM: begin
            new_entry_s.wdata = mem_alu_out;
            wen_raw_s         = 1'b1;
         end
         default: begin
            wen_raw_s = 1'b0;
         end
      endcase
      // x0 is hardwired to zero, so never write it.
      new_entry_s.wen = wen_raw_s && (rd_s != 5'd0);
   end

   // No pass-through: a full queue refuses even when popping this cycle.
   assign mem_ready = (count_q < DEPTH_C);
   assign push_s    = mem_valid && mem_ready && !flush;
   assign pop_s     = (count_q != '0) && rf_ready && !flush;
   assign head_s    = queue_q[rd_ptr_q];

   // Next-state for pointers, occupancy, counter and error pulse.
   always_comb begin
      misalign_d = push_s && entry_mis_s;
      instret_d  = pop_s ? (instret_q + CNT_W'(1)) : instret_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
         wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         instret_q  <= '0;
         misalign_q <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         instret_q  <= instret_d;
         misalign_q <= misalign_d;
      end
   end

   // Queue storage; written only on an accepted push.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            queue_q[i] <= '0;
         end
      end else if (push_s) begin
         queue_q[wr_ptr_q] <= new_entry_s;
      end
   end

   assign retire_valid = pop_s;
   assign rf_we        = pop_s && head_s.wen;
   assign rf_waddr     = head_s.rd;
   assign rf_wdata     = head_s.wdata;
   assign retire_pc    = head_s.pc;
   assign retire_ir    = head_s.ir;
   assign misalign_err = misalign_q;
   assign instret      = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

   typedef struct packed {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [31:0] pc;
      logic [31:0] ir;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid, mem_ready, flush, rf_ready;
   logic [31:0] mem_pc, mem_ir, mem_alu_out, mem_load_data;
   logic        rf_we, retire_valid, misalign_err;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata, retire_pc, retire_ir;
   logic [63:0] instret;

   int   checks = 0;
   int   errors = 0;
   int   n_ret  = 0;
   logic acc;
   exp_t pend;
   exp_t sb[$];
   logic [63:0] base;

   writeback_stage dut (
      .clk(clk), .rst(rst),
      .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_pc(mem_pc), .mem_ir(mem_ir),
      .mem_alu_out(mem_alu_out), .mem_load_data(mem_load_data),
      .flush(flush), .rf_ready(rf_ready),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_ir(retire_ir),
      .misalign_err(misalign_err), .instret(instret)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mk_ir(input logic [6:0] opc, input logic [4:0] rd,
                                         input logic [2:0] f3);
      return {17'd0, f3, rd, opc};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle: check retirement at negedge, record accepted push, advance.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (retire_valid) begin
         chk("retire_expected", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("retire_pc", 64'(retire_pc), 64'(e.pc));
            chk("retire_ir", 64'(retire_ir), 64'(e.ir));
            chk("rf_we", 64'(rf_we), 64'(e.we));
            if (e.we) begin
               chk("rf_waddr", 64'(rf_waddr), 64'(e.waddr));
               chk("rf_wdata", 64'(rf_wdata), 64'(e.wdata));
            end
            n_ret++;
         end
      end
      if (mem_valid && mem_ready && !flush) begin
         sb.push_back(pend);
         acc = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      mem_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic setup(input logic [31:0] pc, input logic [31:0] ir, input logic [31:0] alu,
                        input logic [31:0] ld, input logic we, input logic [31:0] wd);
      mem_pc = pc; mem_ir = ir; mem_alu_out = alu; mem_load_data = ld;
      mem_valid = 1'b1;
      pend = '{we: we, waddr: ir[11:7], wdata: wd, pc: pc, ir: ir};
      acc  = 1'b0;
   endtask

   task automatic drive(input logic [31:0] pc, input logic [31:0] ir, input logic [31:0] alu,
                        input logic [31:0] ld, input logic we, input logic [31:0] wd);
      setup(pc, ir, alu, ld, we, wd);
      for (int k = 0; k < 20 && !acc; k++) tick();
      chk("push_accepted", 64'(acc), 64'd1);
      mem_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b0; mem_valid = 1'b0; flush = 1'b0; rf_ready = 1'b1;
      mem_pc = 32'd0; mem_ir = 32'd0; mem_alu_out = 32'd0; mem_load_data = 32'd0;
      acc = 1'b0; pend = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rst_mem_ready", 64'(mem_ready), 64'd1);
      chk("rst_rf_we", 64'(rf_we), 64'd0);
      chk("rst_retire_valid", 64'(retire_valid), 64'd0);
      chk("rst_instret", instret, 64'd0);
      chk("rst_misalign", 64'(misalign_err), 64'd0);

      // LB sign extension of byte 2
      drive(32'h0000_0040, mk_ir(7'b0000011, 5'd5, 3'b000), 32'h0000_1002, 32'h1280_3456,
            1'b1, 32'hFFFF_FF80);
      chk("lb_no_misalign", 64'(misalign_err), 64'd0);
      idle(1);
      chk("lb_instret", instret, 64'd1);

      // LHU / LH of upper halfword
      drive(32'h0000_0044, mk_ir(7'b0000011, 5'd7, 3'b101), 32'h0000_2002, 32'h8765_4321,
            1'b1, 32'h0000_8765);
      drive(32'h0000_0048, mk_ir(7'b0000011, 5'd7, 3'b001), 32'h0000_2002, 32'h8765_4321,
            1'b1, 32'hFFFF_8765);
      idle(2);

      // JAL link address, including wrap at 2^32
      drive(32'h0000_0100, mk_ir(7'b1101111, 5'd1, 3'b000), 32'h0, 32'h0, 1'b1, 32'h0000_0104);
      drive(32'hFFFF_FFFC, mk_ir(7'b1101111, 5'd1, 3'b000), 32'h0, 32'h0, 1'b1, 32'h0000_0000);
      // LUI passes the ALU result
      drive(32'h0000_0200, mk_ir(7'b0110111, 5'd6, 3'b000), 32'hABCD_E000, 32'h0,
            1'b1, 32'hABCD_E000);
      idle(2);
      chk("instret_after_basic", instret, 64'(n_ret));

      // Backpressure: two entries fill the queue, third held
      rf_ready = 1'b0;
      base = instret;
      drive(32'h0000_0300, mk_ir(7'b0110011, 5'd1, 3'b000), 32'd10, 32'h0, 1'b1, 32'd10);
      drive(32'h0000_0304, mk_ir(7'b0110011, 5'd2, 3'b000), 32'd20, 32'h0, 1'b1, 32'd20);
      setup(32'h0000_0308, mk_ir(7'b0110011, 5'd3, 3'b000), 32'd30, 32'h0, 1'b1, 32'd30);
      chk("bp_full_ready", 64'(mem_ready), 64'd0);
      tick(); tick();
      chk("bp_held", 64'(acc), 64'd0);
      chk("bp_still_full", 64'(mem_ready), 64'd0);
      rf_ready = 1'b1;
      tick();
      chk("bp_ret1", 64'(n_ret), base + 64'd1);
      chk("bp_no_passthrough", 64'(acc), 64'd0);
      tick();
      chk("bp_ret2", 64'(n_ret), base + 64'd2);
      chk("bp_third_accepted", 64'(acc), 64'd1);
      mem_valid = 1'b0;
      tick();
      chk("bp_ret3", 64'(n_ret), base + 64'd3);
      chk("bp_instret", instret, base + 64'd3);

      // SW and rd=0 retire without writing
      base = instret;
      drive(32'h0000_0400, mk_ir(7'b0100011, 5'd3, 3'b010), 32'h0000_1000, 32'h0, 1'b0, 32'h0);
      drive(32'h0000_0404, mk_ir(7'b0110011, 5'd0, 3'b000), 32'd55, 32'h0, 1'b0, 32'h0);
      idle(2);
      chk("nowrite_instret", instret, base + 64'd2);

      // Misaligned LW pulses misalign_err for one cycle
      drive(32'h0000_0500, mk_ir(7'b0000011, 5'd8, 3'b010), 32'h0000_1001, 32'hDEAD_BEEF,
            1'b0, 32'h0);
      chk("misalign_pulse", 64'(misalign_err), 64'd1);
      tick();
      chk("misalign_clear", 64'(misalign_err), 64'd0);
      // Unsupported load funct3: no write, no error
      drive(32'h0000_0504, mk_ir(7'b0000011, 5'd8, 3'b011), 32'h0000_1000, 32'h1234_5678,
            1'b0, 32'h0);
      chk("badf3_no_misalign", 64'(misalign_err), 64'd0);
      idle(2);

      // Flush a full queue; no retire during flush, instret unchanged
      rf_ready = 1'b0;
      drive(32'h0000_0600, mk_ir(7'b0110011, 5'd4, 3'b000), 32'd1, 32'h0, 1'b1, 32'd1);
      drive(32'h0000_0604, mk_ir(7'b0110011, 5'd5, 3'b000), 32'd2, 32'h0, 1'b1, 32'd2);
      chk("flush_full", 64'(mem_ready), 64'd0);
      base = instret;
      flush = 1'b1; rf_ready = 1'b1;
      #1;
      chk("flush_retire_blocked", 64'(retire_valid), 64'd0);
      chk("flush_we_blocked", 64'(rf_we), 64'd0);
      tick();
      flush = 1'b0;
      sb.delete();
      chk("flush_ready", 64'(mem_ready), 64'd1);
      chk("flush_instret", instret, base);
      idle(2);
      chk("flush_empty_instret", instret, base);

      // Asynchronous reset with a full queue
      rf_ready = 1'b0;
      drive(32'h0000_0700, mk_ir(7'b0110011, 5'd4, 3'b000), 32'd7, 32'h0, 1'b1, 32'd7);
      drive(32'h0000_0704, mk_ir(7'b0110011, 5'd5, 3'b000), 32'd8, 32'h0, 1'b1, 32'd8);
      rf_ready = 1'b1;
      #2 rst = 1'b0;
      #1;
      chk("arst_retire_valid", 64'(retire_valid), 64'd0);
      chk("arst_rf_we", 64'(rf_we), 64'd0);
      chk("arst_mem_ready", 64'(mem_ready), 64'd1);
      chk("arst_instret", instret, 64'd0);
      chk("arst_misalign", 64'(misalign_err), 64'd0);
      sb.delete();
      n_ret = 0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      idle(2);
      chk("post_rst_instret", instret, 64'd0);
      drive(32'h0000_0800, mk_ir(7'b0010011, 5'd9, 3'b000), 32'd99, 32'h0, 1'b1, 32'd99);
      idle(1);
      chk("post_rst_retire", instret, 64'd1);
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
